mem_dcache_assoc: RTL and testbench



---
 rtl/mem_dcache_assoc.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mem_dcache_assoc.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dcache_assoc.sv
// mem_dcache_assoc
// N-way set-associative, write-back, write-allocate data cache with
// multi-word lines and byte-masked stores. Sits between the memory stage
// (dreq/dresp) and a single-word memory bus (busreq/busresp). Lines are
// written back and refilled as LINE_WORDS sequential single-word beats.
// Replacement is round-robin per set.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   dreq_*            request from the memory stage (valid/ready handshake)
//   dresp_valid/rdata one-cycle response pulse, load data (0 for stores)
//   busreq_*          word-wide bus beat (valid/ready), wen=1 for write-back
//   busresp_*         read data returned for the single outstanding fill beat

module mem_dcache_assoc #(
  parameter int INDEX_WIDTH = 6,
  parameter int WAY_NUM     = 2,
  parameter int LINE_WORDS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid,
  output logic        dreq_ready,
  input  logic [31:0] dreq_addr,
  input  logic        dreq_wen,
  input  logic [3:0]  dreq_wmask,
  input  logic [31:0] dreq_wdata,
  output logic        dresp_valid,
  output logic [31:0] dresp_rdata,
  output logic        busreq_valid,
  input  logic        busreq_ready,
  output logic [31:0] busreq_addr,
  output logic        busreq_wen,
  output logic [31:0] busreq_wdata,
  input  logic        busresp_valid,
  input  logic [31:0] busresp_rdata
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int OW   = (OFF > 0) ? OFF : 1;
  localparam int WW   = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
  localparam int TW   = 32 - INDEX_WIDTH - OFF - 2;
  localparam int SETS = 1 << INDEX_WIDTH;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WB        = 3'd1;
  localparam logic [2:0] S_FILL_REQ  = 3'd2;
  localparam logic [2:0] S_FILL_WAIT = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [31:0]      data_mem  [SETS][WAY_NUM][LINE_WORDS];
  logic [TW-1:0]    tag_mem   [SETS][WAY_NUM];
  logic             valid_mem [SETS][WAY_NUM];
  logic             dirty_mem [SETS][WAY_NUM];
  logic [WW-1:0]    rr_ptr    [SETS];

  logic [2:0]             state;
  logic [OW-1:0]          beat;
  logic [OW-1:0]          req_off;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TW-1:0]          req_tag;
  logic                   req_wen;
  logic [3:0]             req_wmask;
  logic [31:0]            req_wdata;
  logic [WW-1:0]          victim;

  logic [29:0]            word_addr;
  logic                   addr_unused;
  logic [OW-1:0]          in_off;
  logic [INDEX_WIDTH-1:0] in_idx;
  logic [TW-1:0]          in_tag;

  logic                   hit;
  logic [WW-1:0]          hit_way;
  logic                   inv_found;
  logic [WW-1:0]          inv_way;
  logic [WW-1:0]          rr_cur;
  logic [WW-1:0]          rr_next;
  logic [WW-1:0]          victim_sel;
  logic                   victim_dirty;
  logic                   last_beat;
  logic [31:0]            wb_base;
  logic [31:0]            fill_base;
  logic [31:0]            beat_byte;

  // Byte-lane merge used by both store hits and the store half of a miss.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Split the incoming address. Shifts and masks are used instead of
  // fixed slices so that LINE_WORDS=1 (no offset field) still elaborates.
  assign word_addr   = dreq_addr[31:2];
  assign addr_unused = ^dreq_addr[1:0];
  assign in_off      = OW'(word_addr & 30'(LINE_WORDS - 1));
  assign in_idx      = INDEX_WIDTH'(word_addr >> OFF);
  assign in_tag      = TW'(word_addr >> (OFF + INDEX_WIDTH));

  // Tag lookup across the ways of the addressed set, plus the lowest
  // invalid way, which is preferred over the round-robin pointer when
  // choosing a victim so that a set fills before it starts evicting.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (!hit && valid_mem[in_idx][w] && (tag_mem[in_idx][w] == in_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!inv_found && !valid_mem[in_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
  end

  assign rr_cur       = rr_ptr[in_idx];
  assign rr_next      = (rr_cur == WW'(WAY_NUM - 1)) ? '0 : rr_cur + WW'(1);
  assign victim_sel   = inv_found ? inv_way : rr_cur;
  assign victim_dirty = valid_mem[in_idx][victim_sel] && dirty_mem[in_idx][victim_sel];
  assign last_beat    = (beat == OW'(LINE_WORDS - 1));

  // Bus beat addresses are rebuilt from registered state so they hold
  // steady for as long as the bus stalls a beat.
  assign wb_base   = {tag_mem[req_idx][victim], req_idx, {(OFF + 2){1'b0}}};
  assign fill_base = {req_tag, req_idx, {(OFF + 2){1'b0}}};
  assign beat_byte = 32'(beat) << 2;

  assign dreq_ready   = (state == S_IDLE);
  assign busreq_valid = (state == S_WB) || (state == S_FILL_REQ);
  assign busreq_wen   = (state == S_WB);
  assign busreq_addr  = ((state == S_WB) ? wb_base : fill_base) | beat_byte;
  assign busreq_wdata = (state == S_WB) ? data_mem[req_idx][victim][beat] : 32'd0;

  // Control path: FSM, request capture, beat counter, valid/dirty/rr state
  // and the registered response. Reset drops any transaction in flight,
  // including dirty lines that were never written back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      beat        <= '0;
      victim      <= '0;
      req_off     <= '0;
      req_idx     <= '0;
      req_tag     <= '0;
      req_wen     <= 1'b0;
      req_wmask   <= '0;
      req_wdata   <= '0;
      dresp_valid <= 1'b0;
      dresp_rdata <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
        for (int w = 0; w < WAY_NUM; w++) begin
          valid_mem[s][w] <= 1'b0;
          dirty_mem[s][w] <= 1'b0;
        end
      end
    end else begin
      dresp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dreq_valid) begin
            if (hit) begin
              dresp_valid <= 1'b1;
              if (dreq_wen) begin
                dirty_mem[in_idx][hit_way] <= 1'b1;
                dresp_rdata                <= '0;
              end else begin
                dresp_rdata <= data_mem[in_idx][hit_way][in_off];
              end
            end else begin
              req_off   <= in_off;
              req_idx   <= in_idx;
              req_tag   <= in_tag;
              req_wen   <= dreq_wen;
              req_wmask <= dreq_wmask;
              req_wdata <= dreq_wdata;
              victim    <= victim_sel;
              beat      <= '0;
              if (!inv_found) rr_ptr[in_idx] <= rr_next;
              state <= victim_dirty ? S_WB : S_FILL_REQ;
            end
          end
        end
        S_WB: begin
          if (busreq_ready) begin
            if (last_beat) begin
              beat  <= '0;
              state <= S_FILL_REQ;
            end else begin
              beat <= beat + OW'(1);
            end
          end
        end
        S_FILL_REQ: begin
          if (busreq_ready) state <= S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (busresp_valid) begin
            if (last_beat) begin
              valid_mem[req_idx][victim] <= 1'b1;
              dirty_mem[req_idx][victim] <= 1'b0;
              state                      <= S_RESP;
            end else begin
              beat  <= beat + OW'(1);
              state <= S_FILL_REQ;
            end
          end
        end
        S_RESP: begin
          dresp_valid <= 1'b1;
          if (req_wen) begin
            dirty_mem[req_idx][victim] <= 1'b1;
            dresp_rdata                <= '0;
          end else begin
            dresp_rdata <= data_mem[req_idx][victim][req_off];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data and tag storage. Not reset (valid bits gate their use), but
  // writes are suppressed while reset is asserted so an abandoned
  // transaction cannot land late.
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (state)
        S_IDLE: begin
          if (dreq_valid && hit && dreq_wen)
            data_mem[in_idx][hit_way][in_off] <=
              merge_bytes(data_mem[in_idx][hit_way][in_off], dreq_wdata, dreq_wmask);
        end
        S_FILL_WAIT: begin
          if (busresp_valid) begin
            data_mem[req_idx][victim][beat] <= busresp_rdata;
            if (last_beat) tag_mem[req_idx][victim] <= req_tag;
          end
        end
        S_RESP: begin
          if (req_wen)
            data_mem[req_idx][victim][req_off] <=
              merge_bytes(data_mem[req_idx][victim][req_off], req_wdata, req_wmask);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dcache_assoc.sv
// tb_mem_dcache_assoc
// Directed bench for mem_dcache_assoc at default parameters. A small bus
// responder returns read data one cycle after each read handshake and logs
// every beat; the main sequence issues requests and compares responses,
// latencies and logged bus beats against hand-computed values.

module tb_mem_dcache_assoc;

  logic        clk = 1'b0;
  logic        reset;
  logic        dreq_valid;
  logic        dreq_ready;
  logic [31:0] dreq_addr;
  logic        dreq_wen;
  logic [3:0]  dreq_wmask;
  logic [31:0] dreq_wdata;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
  logic        busreq_valid;
  logic        busreq_ready;
  logic [31:0] busreq_addr;
  logic        busreq_wen;
  logic [31:0] busreq_wdata;
  logic        busresp_valid;
  logic [31:0] busresp_rdata;

  int vectors     = 0;
  int miscompares = 0;

  logic ready_en;
  logic resp_hold;

  int          log_cnt;
  logic [31:0] log_addr  [256];
  logic        log_wen   [256];
  logic [31:0] log_wdata [256];

  assign busreq_ready = ready_en;

  always #5 clk = ~clk;

  mem_dcache_assoc dut (
    .clk          (clk),
    .reset        (reset),
    .dreq_valid   (dreq_valid),
    .dreq_ready   (dreq_ready),
    .dreq_addr    (dreq_addr),
    .dreq_wen     (dreq_wen),
    .dreq_wmask   (dreq_wmask),
    .dreq_wdata   (dreq_wdata),
    .dresp_valid  (dresp_valid),
    .dresp_rdata  (dresp_rdata),
    .busreq_valid (busreq_valid),
    .busreq_ready (busreq_ready),
    .busreq_addr  (busreq_addr),
    .busreq_wen   (busreq_wen),
    .busreq_wdata (busreq_wdata),
    .busresp_valid(busresp_valid),
    .busresp_rdata(busresp_rdata)
  );

  // Backing memory contents: the 0x100 line holds 0xA0..0xA3, every other
  // word reads as 0xB0000000 | address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a >= 32'h100 && a <= 32'h10C) return 32'hA0 + ((a - 32'h100) >> 2);
    return 32'hB000_0000 | a;
  endfunction

  // Bus responder: acts 2ns after each falling edge, logs beats that will
  // handshake on the next rising edge, and answers a read one cycle later
  // unless responses are being held back.
  initial begin
    logic        pending;
    logic [31:0] paddr;
    pending       = 1'b0;
    paddr         = '0;
    log_cnt       = 0;
    busresp_valid = 1'b0;
    busresp_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      busresp_valid = 1'b0;
      busresp_rdata = '0;
      if (reset) begin
        pending = 1'b0;
      end else if (pending && !resp_hold) begin
        busresp_valid = 1'b1;
        busresp_rdata = mem_val(paddr);
        pending       = 1'b0;
      end
      if (!reset && busreq_valid && busreq_ready && log_cnt < 256) begin
        log_addr[log_cnt]  = busreq_addr;
        log_wen[log_cnt]   = busreq_wen;
        log_wdata[log_cnt] = busreq_wen ? busreq_wdata : 32'd0;
        log_cnt++;
        if (!busreq_wen) begin
          pending = 1'b1;
          paddr   = busreq_addr;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [71:0] observed,
                             input logic [71:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input int idx, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata);
    checkOutput(tag, {7'd0, log_wen[idx], log_addr[idx], log_wdata[idx]},
                {7'd0, wen, addr, wdata});
  endtask

  // Present one request at a falling edge and hold it until it is accepted;
  // returns 1ns after the accepting rising edge.
  task automatic sendReq(input logic [31:0] a, input logic w,
                         input logic [3:0] m, input logic [31:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!dreq_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!dreq_ready) checkOutput("dreq_ready_timeout", 72'(dreq_ready), 72'd1);
    dreq_valid = 1'b1;
    dreq_addr  = a;
    dreq_wen   = w;
    dreq_wmask = m;
    dreq_wdata = d;
    @(posedge clk);
    #1;
    dreq_valid = 1'b0;
  endtask

  // Latency 1 means dresp_valid is seen just after the accepting edge.
  task automatic waitResponse(output logic [31:0] rd, output int lat);
    lat = 1;
    while (!dresp_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!dresp_valid) checkOutput("dresp_timeout", 72'(dresp_valid), 72'd1);
    rd = dresp_rdata;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic w,
                               input logic [3:0] m, input logic [31:0] d,
                               output logic [31:0] rd, output int lat,
                               output int first_beat);
    first_beat = log_cnt;
    sendReq(a, w, m, d);
    waitResponse(rd, lat);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          start;
    int          guard;
    logic [31:0] wb_exp [4];

    reset      = 1'b1;
    dreq_valid = 1'b0;
    dreq_addr  = '0;
    dreq_wen   = 1'b0;
    dreq_wmask = '0;
    dreq_wdata = '0;
    ready_en   = 1'b1;
    resp_hold  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_dreq_ready",   72'(dreq_ready),   72'd1);
    checkOutput("rst_dresp_valid",  72'(dresp_valid),  72'd0);
    checkOutput("rst_dresp_rdata",  72'(dresp_rdata),  72'd0);
    checkOutput("rst_busreq_valid", 72'(busreq_valid), 72'd0);
    @(negedge clk);
    reset = 1'b0;

    // Cold load of 0x100: four ascending read beats, word 0 returned
    applyStimulus(32'h100, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("cold_rdata",  72'(rd), 72'hA0);
    checkOutput("cold_lat",    72'(lat), 72'd10);
    checkOutput("cold_nbeats", 72'(log_cnt - start), 72'd4);
    for (int k = 0; k < 4; k++)
      checkBeat("cold_beat", start + k, 1'b0, 32'h100 + 32'(4 * k), 32'h0);

    // Back-to-back hits, one accepted per cycle
    start = log_cnt;
    @(negedge clk);
    dreq_valid = 1'b1;
    dreq_addr  = 32'h100;
    dreq_wen   = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b_valid0", 72'(dresp_valid), 72'd1);
    checkOutput("b2b_rdata0", 72'(dresp_rdata), 72'hA0);
    dreq_addr = 32'h10C;
    @(posedge clk);
    #1;
    dreq_valid = 1'b0;
    checkOutput("b2b_valid1", 72'(dresp_valid), 72'd1);
    checkOutput("b2b_rdata1", 72'(dresp_rdata), 72'hA3);
    checkOutput("b2b_nbeats", 72'(log_cnt - start), 72'd0);

    // Load hit 0x108
    applyStimulus(32'h108, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("hit_rdata", 72'(rd), 72'hA2);
    checkOutput("hit_lat",   72'(lat), 72'd1);

    // Store hit with byte mask, then reload the merged word
    applyStimulus(32'h104, 1'b1, 4'b0101, 32'h1122_3344, rd, lat, start);
    checkOutput("st_hit_rdata", 72'(rd), 72'd0);
    checkOutput("st_hit_lat",   72'(lat), 72'd1);
    applyStimulus(32'h104, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("st_merge_rdata", 72'(rd), 72'h0022_0044);

    // 0x500 fills the invalid way of the same set, no write-back
    applyStimulus(32'h500, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("way1_rdata",  72'(rd), 72'hB000_0500);
    checkOutput("way1_lat",    72'(lat), 72'd10);
    checkOutput("way1_nbeats", 72'(log_cnt - start), 72'd4);

    // 0x900 evicts dirty way 0; write-back beat 2 stalls for 5 cycles
    start = log_cnt;
    sendReq(32'h900, 1'b0, 4'h0, 32'h0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(busreq_valid && busreq_wen && busreq_addr == 32'h108) && guard < 50);
    checkOutput("stall_reach", 72'(busreq_addr), 72'h108);
    ready_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_valid", 72'(busreq_valid), 72'd1);
      checkOutput("stall_addr",  72'(busreq_addr),  72'h108);
      checkOutput("stall_wdata", 72'(busreq_wdata), 72'hA2);
    end
    @(negedge clk);
    ready_en = 1'b1;
    waitResponse(rd, lat);
    checkOutput("evict_rdata",  72'(rd), 72'hB000_0900);
    checkOutput("evict_nbeats", 72'(log_cnt - start), 72'd8);
    wb_exp[0] = 32'hA0;
    wb_exp[1] = 32'h0022_0044;
    wb_exp[2] = 32'hA2;
    wb_exp[3] = 32'hA3;
    for (int k = 0; k < 4; k++)
      checkBeat("evict_wb_beat", start + k, 1'b1, 32'h100 + 32'(4 * k), wb_exp[k]);
    for (int k = 0; k < 4; k++)
      checkBeat("evict_fill_beat", start + 4 + k, 1'b0, 32'h900 + 32'(4 * k), 32'h0);

    // Both resident lines of the set now hit
    applyStimulus(32'h90C, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("hit_90c_rdata", 72'(rd), 72'hB000_090C);
    checkOutput("hit_90c_lat",   72'(lat), 72'd1);
    applyStimulus(32'h500, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("hit_500_rdata", 72'(rd), 72'hB000_0500);
    checkOutput("hit_500_lat",   72'(lat), 72'd1);

    // Store miss on a clean set: fill only, single pulse, rdata 0
    applyStimulus(32'h2000, 1'b1, 4'hF, 32'hCAFE_F00D, rd, lat, start);
    checkOutput("st_miss_rdata",  72'(rd), 72'd0);
    checkOutput("st_miss_lat",    72'(lat), 72'd10);
    checkOutput("st_miss_nbeats", 72'(log_cnt - start), 72'd4);
    checkBeat("st_miss_beat0", start, 1'b0, 32'h2000, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("st_miss_pulse", 72'(dresp_valid), 72'd0);
    applyStimulus(32'h2000, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("st_miss_readback", 72'(rd), 72'hCAFE_F00D);

    // Store with empty mask allocates, leaves data unchanged, marks dirty
    applyStimulus(32'h2400, 1'b1, 4'h0, 32'hFFFF_FFFF, rd, lat, start);
    checkOutput("mask0_rdata", 72'(rd), 72'd0);
    applyStimulus(32'h2400, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("mask0_readback", 72'(rd), 72'hB000_2400);

    // rr_ptr of set 0 starts at way 0: 0x2800 evicts the 0x2000 line
    applyStimulus(32'h2800, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("rr0_rdata",  72'(rd), 72'hB000_2800);
    checkOutput("rr0_lat",    72'(lat), 72'd14);
    checkOutput("rr0_nbeats", 72'(log_cnt - start), 72'd8);
    checkBeat("rr0_wb_beat0", start, 1'b1, 32'h2000, 32'hCAFE_F00D);
    checkBeat("rr0_wb_beat3", start + 3, 1'b1, 32'h200C, 32'hB000_200C);
    checkBeat("rr0_fill_beat0", start + 4, 1'b0, 32'h2800, 32'h0);

    // Pointer advanced to way 1: 0x2C00 evicts the mask-0 dirty line
    applyStimulus(32'h2C00, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("rr1_rdata",  72'(rd), 72'hB000_2C00);
    checkOutput("rr1_nbeats", 72'(log_cnt - start), 72'd8);
    checkBeat("rr1_wb_beat0", start, 1'b1, 32'h2400, 32'hB000_2400);
    checkBeat("rr1_fill_beat0", start + 4, 1'b0, 32'h2C00, 32'h0);

    // Reset while waiting on fill data
    resp_hold = 1'b1;
    sendReq(32'h3000, 1'b0, 4'h0, 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("fw_busreq_valid", 72'(busreq_valid), 72'd0);
    checkOutput("fw_dreq_ready",   72'(dreq_ready),   72'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_busreq_valid", 72'(busreq_valid), 72'd0);
    checkOutput("midrst_dreq_ready",   72'(dreq_ready),   72'd1);
    checkOutput("midrst_dresp_valid",  72'(dresp_valid),  72'd0);
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    resp_hold = 1'b0;

    applyStimulus(32'h3000, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("postrst_rdata",  72'(rd), 72'hB000_3000);
    checkOutput("postrst_lat",    72'(lat), 72'd10);
    checkOutput("postrst_nbeats", 72'(log_cnt - start), 72'd4);
    applyStimulus(32'h500, 1'b0, 4'h0, 32'h0, rd, lat, start);
    checkOutput("postrst_500_nbeats", 72'(log_cnt - start), 72'd4);
    checkOutput("postrst_500_rdata",  72'(rd), 72'hB000_0500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
